// File: rtl/pipelined_approx_adder.sv
// Pipelined adder that splits N bits into STAGES equal segments. The low APPROX_BITS bits use lower-part OR (LOA); the rest are exact.
// Define APPROX_ERR_EN to add the Err output, which is the approximate result minus the exact A+B+Cin for the same beat.
module pipelined_approx_adder #(
  parameter int N           = 16,
  parameter int STAGES      = 4,
  parameter int APPROX_BITS = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         Cin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] Sum,
`ifdef APPROX_ERR_EN
  output logic signed [N+1:0] Err,
`endif
  output logic         Cout
);

  localparam int SEG = N / STAGES;

  logic [STAGES-1:0] v;
  logic [STAGES-1:0] en;

  // Adds one segment. Bits below APPROX_BITS are ORed. Only the top approximate bit emits a carry.
  function automatic logic [SEG:0] seg_add(input logic [SEG-1:0] a, input logic [SEG-1:0] b,
                                           input logic cin, input int base);
    logic [SEG-1:0] s;
    logic           c;
    s = '0;
    c = cin;
    for (int j = 0; j < SEG; j++) begin
      if (base + j < APPROX_BITS) begin
        s[j] = a[j] | b[j] | ((base + j == 0) ? c : 1'b0);
        c    = (base + j == APPROX_BITS - 1) ? (a[j] & b[j]) : 1'b0;
      end else begin
        s[j] = a[j] ^ b[j] ^ c;
        c    = (a[j] & b[j]) | (a[j] & c) | (b[j] & c);
      end
    end
    return {c, s};
  endfunction

  for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
    localparam int LO = gi * SEG;

    logic [N-LO-1:0]       a_cur;
    logic [N-LO-1:0]       b_cur;
    logic                  c_cur;
    logic                  v_cur;
    logic [SEG:0]          seg_res;
    logic [(gi+1)*SEG-1:0] s_nxt;
    logic                  load;
    logic                  v_reg;
    logic                  c_reg;
    logic [(gi+1)*SEG-1:0] s_reg;
`ifdef APPROX_ERR_EN
    logic [N:0]            ex_cur;
    logic [N:0]            ex_reg;
`endif

    assign seg_res = seg_add(a_cur[SEG-1:0], b_cur[SEG-1:0], c_cur, LO);
    assign load    = en[gi] & v_cur;
    assign v[gi]   = v_reg;
    assign en[gi]  = out_ready | ~(&v[STAGES-1:gi]);

    if (gi == 0) begin : g_head
      assign a_cur = A;
      assign b_cur = B;
      assign c_cur = Cin;
      assign v_cur = in_valid;
      assign s_nxt = seg_res[SEG-1:0];
`ifdef APPROX_ERR_EN
      assign ex_cur = {1'b0, A} + {1'b0, B} + {{N{1'b0}}, Cin};
`endif
    end else begin : g_body
      assign a_cur = g_stage[gi-1].g_skew.a_reg;
      assign b_cur = g_stage[gi-1].g_skew.b_reg;
      assign c_cur = g_stage[gi-1].c_reg;
      assign v_cur = v[gi-1];
      assign s_nxt = {seg_res[SEG-1:0], g_stage[gi-1].s_reg};
`ifdef APPROX_ERR_EN
      assign ex_cur = g_stage[gi-1].ex_reg;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v_reg <= 1'b0;
        c_reg <= 1'b0;
        s_reg <= '0;
      end else if (en[gi]) begin
        v_reg <= v_cur;
        if (v_cur) begin
          c_reg <= seg_res[SEG];
          s_reg <= s_nxt;
        end
      end
    end

`ifdef APPROX_ERR_EN
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        ex_reg <= '0;
      end else if (load) begin
        ex_reg <= ex_cur;
      end
    end
`endif

    // Only operand bits above this segment travel on with the beat.
    if (gi < STAGES - 1) begin : g_skew
      logic [N-LO-SEG-1:0] a_reg;
      logic [N-LO-SEG-1:0] b_reg;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_reg <= '0;
          b_reg <= '0;
        end else if (load) begin
          a_reg <= a_cur[N-LO-1:SEG];
          b_reg <= b_cur[N-LO-1:SEG];
        end
      end
    end
  end

  assign in_ready  = en[0];
  assign out_valid = v[STAGES-1];
  assign Sum       = g_stage[STAGES-1].s_reg;
  assign Cout      = g_stage[STAGES-1].c_reg;
`ifdef APPROX_ERR_EN
  assign Err = $signed({1'b0, Cout, Sum}) - $signed({1'b0, g_stage[STAGES-1].ex_reg});
`endif

endmodule

// File: tb/tb_pipelined_approx_adder.sv
// Testbench for pipelined_approx_adder. It checks the default instance and an exact instance (APPROX_BITS=0) against a reference model kept in the bench.
// It covers directed cases, back-pressure, bubble collapse, randomized traffic and a reset asserted mid-stream.
module tb_pipelined_approx_adder;
  localparam int LAT = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        cin = 1'b0;
  logic        in_ready, out_valid, cout;
  logic        in_ready0, out_valid0, cout0;
  logic [15:0] sum, sum0;
`ifdef APPROX_ERR_EN
  logic signed [17:0] err, err0;
`endif

  always #5 clk = ~clk;

  pipelined_approx_adder #(.N(16), .STAGES(4), .APPROX_BITS(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .A(a), .B(b), .Cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .Sum(sum),
`ifdef APPROX_ERR_EN
    .Err(err),
`endif
    .Cout(cout)
  );

  pipelined_approx_adder #(.N(16), .STAGES(4), .APPROX_BITS(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
    .A(a), .B(b), .Cin(cin), .out_valid(out_valid0), .out_ready(out_ready),
    .Sum(sum0),
`ifdef APPROX_ERR_EN
    .Err(err0),
`endif
    .Cout(cout0)
  );

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [16:0] r4;
    logic [16:0] r0;
    int          e4;
  } exp_t;

  exp_t        q[$];
  int          n_tests = 0;
  int          n_fail = 0;
  int          n_out = 0;
  logic        prev_stall = 1'b0;
  logic [16:0] hold_val = '0;

  // LOA model: OR the low ab bits, then add the upper parts as whole numbers.
  function automatic logic [16:0] ref_add(int unsigned x, int unsigned y, int unsigned c, int ab);
    int unsigned mask, low, carry, high;
    mask  = (32'd1 << ab) - 1;
    low   = (x | y) & mask;
    if (ab > 0) low = low | c;
    carry = (ab > 0) ? ((x >> (ab - 1)) & (y >> (ab - 1)) & 1) : c;
    high  = (x >> ab) + (y >> ab) + carry;
    return 17'((high << ab) | low);
  endfunction

  function automatic exp_t make_exp(logic [15:0] x, logic [15:0] y, logic c);
    exp_t e;
    e.a   = x;
    e.b   = y;
    e.cin = c;
    e.r4  = ref_add(32'(x), 32'(y), 32'(c), 4);
    e.r0  = ref_add(32'(x), 32'(y), 32'(c), 0);
    e.e4  = int'(e.r4) - (int'(x) + int'(y) + int'(c));
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_tests++;
    assert (obs === want) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
    end
  endtask

  // Samples both handshakes before the edge, checks consumed beats against the scoreboard, then advances one cycle.
  task automatic tick();
    exp_t e;
    #1;
    if (prev_stall) begin
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_sum", 32'({cout, sum}), 32'(hold_val));
    end
    prev_stall = out_valid && !out_ready;
    hold_val   = {cout, sum};
    if (in_valid && in_ready) q.push_back(make_exp(a, b, cin));
    if (out_valid && out_ready) begin
      n_out++;
      if (q.size() == 0) begin
        check("spurious_beat", 32'(out_valid), 32'd0);
      end else begin
        e = q.pop_front();
        $display("[TB] beat a=%h b=%h cin=%b sum=%h cout=%b sum0=%h cout0=%b",
                 e.a, e.b, e.cin, sum, cout, sum0, cout0);
        check("sum", 32'(sum), 32'(e.r4[15:0]));
        check("cout", 32'(cout), 32'(e.r4[16]));
        check("sum_exact", 32'(sum0), 32'(e.r0[15:0]));
        check("cout_exact", 32'(cout0), 32'(e.r0[16]));
`ifdef APPROX_ERR_EN
        check("err", 32'(err), 32'(18'(e.e4)));
        check("err_exact", 32'(err0), 32'd0);
`endif
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic directed(input logic [15:0] x, input logic [15:0] y, input logic c,
                          input logic [16:0] x4, input logic [16:0] x0, input int xe);
    a = x; b = y; cin = c; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    check("dir_in_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    for (int k = 1; k <= LAT; k++) begin
      check("dir_latency", 32'(out_valid), (k == LAT) ? 32'd1 : 32'd0);
      if (k < LAT) tick();
    end
    check("dir_result", 32'({cout, sum}), 32'(x4));
    check("dir_result_exact", 32'({cout0, sum0}), 32'(x0));
`ifdef APPROX_ERR_EN
    check("dir_err", 32'(err), 32'(18'(xe)));
`else
    if (xe != 0) $display("[TB] reference error for this beat is %0d", xe);
`endif
    tick();
  endtask

  task automatic drain(input string tag);
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int t = 0; t < 40 && q.size() > 0; t++) tick();
    check(tag, 32'(q.size()), 32'd0);
  endtask

  initial begin
    int acc;
    int out_start;

    #2 rst_n = 1'b0;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_cout", 32'(cout), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;

    directed(16'h00FF, 16'h0001, 1'b0, 17'h000FF, 17'h00100, -1);
    directed(16'hFFFF, 16'h0001, 1'b0, 17'h0FFFF, 17'h10000, -1);
    directed(16'h0008, 16'h0008, 1'b1, 17'h00019, 17'h00011, 8);

    // Back-pressure: four beats fill the pipe, then in_ready drops.
    out_ready = 1'b0;
    acc = 0;
    out_start = n_out;
    for (int cyc = 0; cyc < 6; cyc++) begin
      a = 16'(acc + 1); b = 16'(acc + 1); cin = 1'b0; in_valid = 1'b1;
      #1;
      if (in_ready) acc++;
      tick();
    end
    #1;
    check("bp_accepted", 32'(acc), 32'd4);
    check("bp_full_in_ready", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    #1;
    check("bp_comb_in_ready", 32'(in_ready), 32'd1);
    for (int t = 0; t < 40 && (acc < 6 || q.size() > 0); t++) begin
      if (acc < 6) begin
        a = 16'(acc + 1); b = 16'(acc + 1); in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (in_valid && in_ready) acc++;
      tick();
    end
    in_valid = 1'b0;
    check("bp_drained", 32'(q.size()), 32'd0);
    check("bp_beats_out", 32'(n_out - out_start), 32'd6);

    // Bubble collapse: an empty stage still accepts while the output is stalled.
    out_ready = 1'b0;
    a = 16'h0123; b = 16'h0456; cin = 1'b1; in_valid = 1'b1;
    tick();
    for (int k = 0; k < 3; k++) begin
      a = 16'($urandom()); b = 16'($urandom()); cin = 1'($urandom_range(0, 1));
      #1;
      check("bubble_in_ready", 32'(in_ready), 32'd1);
      tick();
    end
    in_valid = 1'b0;
    #1;
    check("bubble_full", 32'(in_ready), 32'd0);
    drain("bubble_drained");

    // Randomized traffic with random stalls and some saturated operands.
    for (int t = 0; t < 300; t++) begin
      a = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom());
      b = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom());
      cin = 1'($urandom_range(0, 1));
      in_valid = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    drain("rand_drained");

    // Reset mid-stream with three beats in flight.
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      a = 16'($urandom()); b = 16'($urandom()); cin = 1'b1; in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    tick();
    check("rst_pre_valid", 32'(out_valid), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("rst_mid_out_valid", 32'(out_valid), 32'd0);
    check("rst_mid_sum", 32'(sum), 32'd0);
    check("rst_mid_cout", 32'(cout), 32'd0);
    check("rst_mid_in_ready", 32'(in_ready), 32'd1);
    q.delete();
    prev_stall = 1'b0;
    @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      check("rst_no_stale", 32'(out_valid), 32'd0);
      tick();
    end
    directed(16'h1234, 16'h4321, 1'b0, 17'h05555, 17'h05555, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pipelined_approx_adder.md
Name: pipelined_approx_adder

Overview:
- Parametrised, pipelined successor to the combinational ripple-carry approximate adder.
- N-bit addition is split into STAGES equal segments. Each segment is added in its own register stage, and the carry is registered between stages.
- The lowest APPROX_BITS bits use lower-part OR (LOA) approximation. The remaining bits are exact.
- Valid/ready handshakes on both sides let the block sit between the Vedic partial-product stage and the final accumulation stage of the approximate multiplier.

Parameters:
- N, 16: operand and sum width.
- STAGES, 4: pipeline depth. N must be divisible by STAGES; the segment width is SEG = N/STAGES.
- APPROX_BITS, 4: LSBs computed approximately. Range 0..N; 0 means a fully exact adder.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  block can accept a beat this cycle.
- A  input  N  operand A.
- B  input  N  operand B.
- Cin  input  1  carry in.
- out_valid  output  1  result beat valid.
- out_ready  input  1  downstream accepts the result.
- Sum  output  N  result.
- Cout  output  1  carry out of bit N-1.

Behaviour:
- Interface: one clock, clk. Reset is asynchronous and active-low on rst_n. All registers clear while rst_n=0; release is synchronous to clk.
- Reset values: out_valid=0, Sum=0, Cout=0, all stage valid bits 0, all data and carry registers 0. in_ready=1 after reset.
- Approximate region, bits [APPROX_BITS-1:0]:
  - s[i] = A[i] | B[i].
  - Bit 0 additionally ORs in Cin.
  - Carry into bit APPROX_BITS = A[APPROX_BITS-1] & B[APPROX_BITS-1].
  - Cin affects only bit 0 when APPROX_BITS>0.
- Exact region: bits [N-1:APPROX_BITS] form a ripple-carry sum, seeded by the carry above (or by Cin when APPROX_BITS=0).
- Pipeline structure:
  - Stage k (0..STAGES-1) computes bits [k*SEG+SEG-1 : k*SEG] from its operand slice and the registered carry of stage k-1.
  - Stage 0 uses Cin.
  - Higher operand slices and the completed lower sum bits are skew-registered alongside the beat.
  - The approximation boundary may fall mid-segment; the per-bit rule still applies.
- Latency: exactly STAGES cycles from an accepted input beat to out_valid, with no stalls. Throughput is 1 beat/cycle.
- Handshake:
  - An input beat is accepted when in_valid & in_ready. An output beat is consumed when out_valid & out_ready.
  - Per-stage enable: en[STAGES-1] = ~v[STAGES-1] | out_ready; en[k] = ~v[k] | en[k+1]. in_ready = en[0].
  - Bubbles collapse: an empty stage accepts even while downstream is stalled.
  - A stage holds its data unchanged while its enable is 0.
  - Sum/Cout stay stable while out_valid=1 and out_ready=0.
- Full pipeline: all v=1 and out_ready=0 give in_ready=0. When out_ready rises, in_ready rises combinationally in the same cycle, so simultaneous in/out transfers sustain full rate.
- Reset mid-operation: all in-flight beats are discarded; no partial output appears after reset.
- Width rules: Cout is the true carry out of bit N-1 of the approximate computation. No overflow flag.

Optional Feature:
- Macro: APPROX_ERR_EN.
- When defined:
  - Adds output port Err, signed N+2 bits, equal to ({Cout,Sum}) - (A+B+Cin exact) for the same beat.
  - Computed with a parallel exact adder delayed to match; it is valid and held under the same out_valid/out_ready rules.
  - Reset value 0.
- When undefined: no Err port and no exact-adder hardware; all other behaviour is identical.

Test Plan:
- Defaults. A=0x00FF, B=0x0001, Cin=0, out_ready=1 -> after 4 cycles Sum=0x00FF, Cout=0. With APPROX_ERR_EN, Err=-1.
- APPROX_BITS=0. A=0xFFFF, B=0x0001, Cin=0 -> Sum=0x0000, Cout=1, 4-cycle latency.
- Defaults. A=0x0008, B=0x0008, Cin=1 -> Sum=0x0019, Cout=0. With APPROX_ERR_EN, Err=+8.
- Back-pressure:
  - Stream 6 beats (A=i, B=i, i=1..6) with out_ready held 0 -> exactly 4 accepted, then in_ready=0.
  - Raise out_ready -> results emerge in order with no loss or duplication, and Sum is held stable during the stall.
- Bubble collapse. One beat in flight, out_ready=0 for 3 cycles, in_valid pulsed each cycle -> in_ready stays 1 until all stage valid bits are 1.
- Reset mid-stream. Assert rst_n=0 asynchronously with 3 beats in flight -> out_valid=0 and Sum=0 immediately; after release, no stale beat appears.
